// File: rtl/cnn16_conv3x3_engine_if.sv
// rtl/cnn16_conv3x3_engine_if.sv - single-port CNN data RAM bus between engine and RAM
interface cnn16_conv3x3_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_write, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_write, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/cnn16_conv3x3_engine.sv
// rtl/cnn16_conv3x3_engine.sv - 3x3 valid-convolution engine, Q8.8 MAC, saturated write-back
module cnn16_conv3x3_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] kern_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    output logic                  busy,
    output logic                  done,
    cnn16_conv3x3_engine_if.master mem
);
    typedef enum logic [2:0] {IDLE, LOAD_K, CONV, DRAIN, WRITE, DONE} state_t;

    state_t                       state, state_nx;
    logic   [3:0]                 idx;
    logic   [1:0]                 ki, kj;
    logic   [ADDR_WIDTH-1:0]      r, c;
    logic   [ADDR_WIDTH-1:0]      src_q, kern_q, dst_q;
    logic signed [DATA_WIDTH-1:0] k [9];
    logic signed [35:0]           acc;
    logic                         cap_k, cap_p;
    logic   [3:0]                 cap_idx;
    logic signed [31:0]           prod;
    logic signed [27:0]           shifted;
    logic   [DATA_WIDTH-1:0]      sat;
    logic                         last_pos;
    logic   [ADDR_WIDTH-1:0]      pix_addr, out_addr;

    assign last_pos = (r == ADDR_WIDTH'(IMG_H - 3)) && (c == ADDR_WIDTH'(IMG_W - 3));
    assign pix_addr = src_q + (r + ADDR_WIDTH'(ki)) * ADDR_WIDTH'(IMG_W) + c + ADDR_WIDTH'(kj);
    assign out_addr = dst_q + r * ADDR_WIDTH'(IMG_W - 2) + c;
    assign prod     = $signed(mem.mem_rdata) * k[cap_idx];
    // Taking the upper bits of a signed value is an arithmetic (floor) shift by 8.
    assign shifted  = acc[35:8];

    always_comb begin
        if (shifted > 28'sd32767)
            sat = 16'h7FFF;
        else if (shifted < -28'sd32768)
            sat = 16'h8000;
        else
            sat = shifted[15:0];
    end

    assign busy = (state == LOAD_K) || (state == CONV) || (state == DRAIN) || (state == WRITE);
    assign done = (state == DONE);

    always_comb begin
        state_nx      = state;
        mem.mem_write = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            IDLE:   if (start) state_nx = LOAD_K;
            LOAD_K: begin
                if (idx != 4'd9) mem.mem_addr = kern_q + ADDR_WIDTH'(idx);
                if (idx == 4'd9) state_nx = CONV;
            end
            CONV: begin
                mem.mem_addr = pix_addr;
                if (idx == 4'd8) state_nx = DRAIN;
            end
            DRAIN:  state_nx = WRITE;
            WRITE: begin
                mem.mem_write = 1'b1;
                mem.mem_addr  = out_addr;
                mem.mem_wdata = sat;
                state_nx      = last_pos ? DONE : CONV;
            end
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            ki      <= '0;
            kj      <= '0;
            r       <= '0;
            c       <= '0;
            src_q   <= '0;
            kern_q  <= '0;
            dst_q   <= '0;
            acc     <= '0;
            cap_k   <= 1'b0;
            cap_p   <= 1'b0;
            cap_idx <= '0;
            for (int i = 0; i < 9; i++) k[i] <= '0;
        end else begin
            state   <= state_nx;
            // Read data returns one cycle after its address, so tag it with the issuing index.
            cap_k   <= (state == LOAD_K) && (idx != 4'd9);
            cap_p   <= (state == CONV);
            cap_idx <= idx;
            if (cap_k) k[cap_idx] <= $signed(mem.mem_rdata);
            if (cap_p) acc <= acc + {{4{prod[31]}}, prod};
            case (state)
                IDLE: if (start) begin
                    src_q  <= src_base;
                    kern_q <= kern_base;
                    dst_q  <= dst_base;
                    idx    <= '0;
                end
                LOAD_K: begin
                    idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
                    if (idx == 4'd9) begin
                        r  <= '0;
                        c  <= '0;
                        ki <= '0;
                        kj <= '0;
                    end
                end
                CONV: begin
                    if (idx == 4'd0) acc <= '0;
                    idx <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
                    kj  <= (kj == 2'd2) ? 2'd0 : kj + 2'd1;
                    if (kj == 2'd2) ki <= (ki == 2'd2) ? 2'd0 : ki + 2'd1;
                end
                WRITE: begin
                    if (c == ADDR_WIDTH'(IMG_W - 3)) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cnn16_conv3x3_engine.md
# cnn16_conv3x3_engine

3x3 valid-convolution engine that is the sole master of the 16-bit, 4096-word single-port CNN data RAM. It fetches a 9-word kernel and an IMG_W x IMG_H feature map from the RAM and computes each output pixel with a signed Q8.8 multiply-accumulate. It writes the (IMG_W-2) x (IMG_H-2) saturated result map back into the same RAM. It drives the RAM's mem_write/address/data_in and consumes its registered data_out.

## Interface
- DATA_WIDTH, 16, pixel/weight width (signed Q8.8).
- ADDR_WIDTH, 12, RAM address width.
- IMG_W, 16, input map width in pixels (>= 3).
- IMG_H, 16, input map height in pixels (>= 3).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled in IDLE only.
- src_base  in  ADDR_WIDTH  address of input pixel (0,0); row-major.
- kern_base  in  ADDR_WIDTH  address of weight w[0][0]; 9 words, row-major.
- dst_base  in  ADDR_WIDTH  address of output pixel (0,0); row-major, width IMG_W-2.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at end of run.
- mem_write  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM registered read data, valid the cycle after the address is presented with mem_write=0.

## Operation
- States: IDLE, LOAD_K, CONV, DRAIN, WRITE, DONE.
- IDLE: if start=1, latch src_base/kern_base/dst_base and go to LOAD_K. start in any other state is ignored.
- LOAD_K: 9 cycles issuing kern_base+0..8, then 1 drain cycle. Each returned word is stored in weight register k[i] one cycle after its address. Then go to CONV with output position (r,c)=(0,0).
- CONV: 9 cycles issuing src_base + (r+i)*IMG_W + (c+j) for i,j = 0..2, j fastest. The accumulator clears on the first issue cycle. Each product pixel*k[3i+j] (32-bit signed) adds into a 36-bit signed accumulator one cycle after its address.
- DRAIN: 1 cycle to accumulate the 9th product, then go to WRITE.
- WRITE: mem_write=1, mem_addr = dst_base + r*(IMG_W-2) + c, mem_wdata = sat16(acc >>> 8).
  - sat16 clamps to 0x7FFF / 0x8000; the shift is arithmetic (floor).
  - Advance c, then r. If the last position (IMG_H-3, IMG_W-3) has been written, go to DONE; else go to CONV.
- DONE: done=1 for one cycle, then IDLE.
- All address arithmetic is modulo 2^ADDR_WIDTH; it wraps silently.
- busy=1 in LOAD_K, CONV, DRAIN and WRITE; 0 in IDLE and DONE.
- mem_write=1 only in WRITE.

## Timing
- Reset values: busy=0, done=0, mem_write=0, mem_addr=0, mem_wdata=0, state IDLE. Weights and accumulator clear to 0.
- Asserting rst_n low mid-run aborts immediately and asynchronously: mem_write drops, no further writes occur, and earlier written outputs remain in RAM.
- Start accepted at edge T: busy=1 from T+1.
- Per output pixel: 11 cycles (9 issue, 1 drain, 1 write).
- With N=(IMG_W-2)*(IMG_H-2), busy is high for 10+11N cycles, followed by done for 1 cycle. start may be re-accepted in the cycle after done.
- A start held high in the DONE cycle is not seen; it is seen in the next cycle (IDLE).

## Test plan
- Identity kernel (0x0100 at centre, 0 elsewhere), 4x4 map of values 1..16 at src 0x000, dst 0x100 -> RAM[0x100..0x103] = 6,7,10,11; done pulses.
- All weights 0x0100, all pixels 0x0100 -> every output 0x0900.
- Saturation: all weights 0x0100, pixels 0x7FFF -> outputs 0x7FFF. With pixels 0x8000 -> outputs 0x8000. Weights 0xFF00, pixels 0x0100 -> outputs 0xF700.
- Cycle count at IMG_W=IMG_H=4: busy high exactly 54 cycles, exactly 4 mem_write pulses, done 1 cycle; a start pulse during busy causes no second run.
- Wrap: src_base=0xFFE on a 4x4 map -> reads wrap to 0x000+. Results match a reference model using modulo-4096 addressing.
- Reset mid-run at the 20th busy cycle -> mem_write=0, busy=0 immediately. A fresh start afterwards produces the full correct output map.
